// File: rtl/reg_file_sb.sv
// Dual-read register file with per-register pending (scoreboard) bits; reads and busy flags are combinational from stored state.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_sb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SELW = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  input  logic [SELW-1:0]          selW,
  input  logic                     load_L,
  input  logic [SELW-1:0]          selA,
  input  logic [SELW-1:0]          selB,
  output logic [WIDTH-1:0]         outA,
  output logic [WIDTH-1:0]         outB,
  input  logic                     rsv,
  input  logic [SELW-1:0]          rsvSel,
  output logic                     busyA,
  output logic                     busyB,
  output logic                     anyBusy,
  output logic [WIDTH*DEPTH-1:0]   outView
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            pend_q, pend_d;

  // Reserve is applied after the write so a same-index collision leaves the register pending.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (!load_L) begin
      regs_d[selW] = in;
      pend_d[selW] = 1'b0;
    end
    if (rsv) begin
      pend_d[rsvSel] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign outView = regs_q;
  assign anyBusy = |pend_q;

`ifdef REG_FILE_SB_BYPASS_EN
  logic fwd_a, fwd_b, rsv_hit;

  // A forwarded read sees the retiring write, so it is only busy if re-reserved this cycle.
  assign fwd_a   = !load_L && (selA == selW);
  assign fwd_b   = !load_L && (selB == selW);
  assign rsv_hit = rsv && (rsvSel == selW);

  assign outA  = fwd_a ? in : regs_q[selA];
  assign outB  = fwd_b ? in : regs_q[selB];
  assign busyA = fwd_a ? rsv_hit : pend_q[selA];
  assign busyB = fwd_b ? rsv_hit : pend_q[selB];
`else
  assign outA  = regs_q[selA];
  assign outB  = regs_q[selB];
  assign busyA = pend_q[selA];
  assign busyB = pend_q[selB];
`endif

endmodule
